// File: rtl/ysyx_22050019_lsu.sv
// Load/store initiator: one core access at a time, aligned byte-masked memory request, extended load return.
// Latency: misaligned 1 cycle, store 2 cycles, load 3 cycles after the request handshake (zero-wait memory).
// Backpressure: req_ready only in IDLE; mem_* held stable until mem_ready; optional timeout aborts with err=2.
module ysyx_22050019_lsu #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_mask,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    typedef struct packed {
        logic [1:0] size;
        logic       uns;
        logic [2:0] off;
    } meta_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state, state_nxt;
    meta_t            meta;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      rdata_q;
    logic [1:0]       err_q;
    logic             misaligned;
    logic             to_hit;
    logic [2:0]       in_off;
    logic [7:0]       mask_base;
    logic [63:0]      ld_shift;
    logic [63:0]      ld_ext;

    assign in_off = req_addr[2:0];
    assign to_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        misaligned = 1'b0;
        mask_base  = 8'h01;
        case (req_size)
            2'd0: begin misaligned = 1'b0;           mask_base = 8'h01; end
            2'd1: begin misaligned = req_addr[0];    mask_base = 8'h03; end
            2'd2: begin misaligned = |req_addr[1:0]; mask_base = 8'h0F; end
            default: begin misaligned = |req_addr[2:0]; mask_base = 8'hFF; end
        endcase
    end

    // Memory returns the whole doubleword; bring the addressed lane down to bit 0 first.
    assign ld_shift = mem_rdata >> {meta.off, 3'b000};

    always_comb begin
        ld_ext = ld_shift;
        case (meta.size)
            2'd0: ld_ext = {{56{~meta.uns & ld_shift[7]}},  ld_shift[7:0]};
            2'd1: ld_ext = {{48{~meta.uns & ld_shift[15]}}, ld_shift[15:0]};
            2'd2: ld_ext = {{32{~meta.uns & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = misaligned ? RESP : REQ;
            REQ: begin
                if (mem_ready)   state_nxt = mem_wen ? RESP : WAIT_R;
                else if (to_hit) state_nxt = RESP;
            end
            WAIT_R: begin
                if (mem_rvalid)  state_nxt = RESP;
                else if (to_hit) state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_valid = (state == REQ);
        rsp_valid = (state == RESP);
        rsp_rdata = (state == RESP) ? rdata_q : 64'd0;
        rsp_err   = (state == RESP) ? err_q : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            meta      <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            err_q     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    mem_wen   <= req_wen;
                    mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                    mem_wdata <= req_wdata << {in_off, 3'b000};
                    mem_mask  <= mask_base << in_off;
                    meta      <= '{size: req_size, uns: req_unsigned, off: in_off};
                    cnt       <= '0;
                    rdata_q   <= '0;
                    err_q     <= misaligned ? 2'd1 : 2'd0;
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!mem_ready && to_hit) err_q <= 2'd2;
                end
                WAIT_R: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_rvalid)  rdata_q <= ld_ext;
                    else if (to_hit) err_q   <= 2'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Directed bench for ysyx_22050019_lsu: main instance (default timeout) plus a TIMEOUT=4 instance on shared stimulus.
module tb_ysyx_22050019_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_wen, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        req_ready, rsp_valid, mem_valid, mem_wen;
    logic [63:0] rsp_rdata, mem_addr, mem_wdata;
    logic [1:0]  rsp_err;
    logic [7:0]  mem_mask;

    logic        b_req_ready, b_rsp_valid, b_mem_valid, b_mem_wen;
    logic [63:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_rsp_err;
    logic [7:0]  b_mem_mask;

    int n_chk = 0;
    int n_err = 0;

    ysyx_22050019_lsu u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    ysyx_22050019_lsu #(.ADDR_W(64), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_wen(b_mem_wen),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_mask(b_mem_mask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expand(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns);
        req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] size, input logic [7:0] exp_mask, input logic [63:0] exp_wd);
        mem_ready = 1'b1;
        issue(1'b1, addr, wdata, size, 1'b0);
        chk({tag, " mem_valid"}, mem_valid, 1);
        chk({tag, " mem_wen"},   mem_wen, 1);
        chk({tag, " mem_addr"},  mem_addr, {addr[63:3], 3'b000});
        chk({tag, " mem_mask"},  mem_mask, exp_mask);
        chk({tag, " mem_wdata"}, mem_wdata & expand(exp_mask), exp_wd);
        chk({tag, " early_rsp"}, rsp_valid, 0);
        step();
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_err"},   rsp_err, 0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 0);
        chk({tag, " mem_drop"},  mem_valid, 0);
        step();
        chk({tag, " rsp_pulse"}, rsp_valid, 0);
        chk({tag, " ready"},     req_ready, 1);
    endtask

    task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                           input logic uns, input logic [63:0] rdata, input logic [7:0] exp_mask,
                           input logic [63:0] exp);
        mem_ready = 1'b1;
        issue(1'b0, addr, 64'd0, size, uns);
        chk({tag, " mem_valid"}, mem_valid, 1);
        chk({tag, " mem_addr"},  mem_addr, {addr[63:3], 3'b000});
        chk({tag, " mem_mask"},  mem_mask, exp_mask);
        step();
        chk({tag, " wait_rsp"},  rsp_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step();
        mem_rvalid = 1'b0;
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_rdata"}, rsp_rdata, exp);
        chk({tag, " rsp_err"},   rsp_err, 0);
        step();
        chk({tag, " rsp_pulse"}, rsp_valid, 0);
        chk({tag, " ready"},     req_ready, 1);
    endtask

    task automatic do_mis(input string tag, input logic [63:0] addr, input logic [1:0] size);
        mem_ready = 1'b1;
        issue(1'b0, addr, 64'd0, size, 1'b0);
        chk({tag, " mem_valid"}, mem_valid, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_err"},   rsp_err, 1);
        chk({tag, " rsp_rdata"}, rsp_rdata, 0);
        step();
        chk({tag, " rsp_pulse"}, rsp_valid, 0);
        chk({tag, " mem_idle"},  mem_valid, 0);
        chk({tag, " ready"},     req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst req_ready", req_ready, 1);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst rsp_err",   rsp_err, 0);
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_wen",   mem_wen, 0);
        chk("rst mem_addr",  mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_mask",  mem_mask, 0);
        #20 rst_n = 1'b1;
        step();

        // Back-to-back: each task issues in the IDLE cycle the previous one ended in.
        do_store("st_b",  64'h8000_0005, 64'hAB,   2'd0, 8'h20, 64'h0000_AB00_0000_0000);
        do_store("st_h",  64'h8000_000A, 64'h1234, 2'd1, 8'h0C, 64'h0000_0000_1234_0000);
        do_load("ld_hs",  64'h8000_0006, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 8'hC0, 64'hFFFF_FFFF_FFFF_8001);
        do_load("ld_hu",  64'h8000_0006, 2'd1, 1'b1, 64'h8001_0000_0000_0000, 8'hC0, 64'h0000_0000_0000_8001);
        do_load("ld_ws",  64'h8000_0004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 8'hF0, 64'hFFFF_FFFF_8765_4321);
        do_load("ld_bu",  64'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_F000_0000, 8'h08, 64'h0000_0000_0000_00F0);
        do_load("ld_bs",  64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_F000_0000, 8'h08, 64'hFFFF_FFFF_FFFF_FFF0);
        do_load("ld_bp",  64'h8000_0001, 2'd0, 1'b0, 64'h0000_0000_0000_7F00, 8'h02, 64'h0000_0000_0000_007F);
        do_mis("mis_w",   64'h8000_0002, 2'd2);
        do_mis("mis_h",   64'h8000_0001, 2'd1);
        do_mis("mis_d",   64'h8000_0004, 2'd3);

        // Ready backpressure: five stalled cycles then acceptance on the sixth.
        mem_ready = 1'b0;
        issue(1'b0, 64'h8000_0010, 64'd0, 2'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) mem_ready = 1'b1;
            chk("bp mem_valid", mem_valid, 1);
            chk("bp mem_addr",  mem_addr, 64'h8000_0010);
            chk("bp mem_mask",  mem_mask, 8'hFF);
            chk("bp mem_wen",   mem_wen, 0);
            step();
        end
        chk("bp single_accept", mem_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        mem_rvalid = 1'b0;
        chk("bp rsp_valid", rsp_valid, 1);
        chk("bp rsp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        step();
        step();

        // Timeout on the TIMEOUT=4 instance; the main instance keeps waiting.
        mem_ready = 1'b1; mem_rvalid = 1'b0;
        issue(1'b0, 64'h8000_0020, 64'd0, 2'd3, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk("to pending", b_rsp_valid, 0);
            step();
        end
        chk("to rsp_valid", b_rsp_valid, 1);
        chk("to rsp_err",   b_rsp_err, 2);
        chk("to rsp_rdata", b_rsp_rdata, 0);
        chk("to mem_valid", b_mem_valid, 0);
        step();
        chk("to ready", b_req_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_1111;
        step();
        mem_rvalid = 1'b0;
        chk("to main_rsp",   rsp_valid, 1);
        chk("to main_rdata", rsp_rdata, 64'hDEAD_BEEF_0000_1111);
        for (int i = 0; i < 4; i++) begin
            chk("to late_rvalid", b_rsp_valid, 0);
            step();
        end

        // Reset while a request is presented to memory.
        mem_ready = 1'b0;
        issue(1'b0, 64'h8000_0030, 64'd0, 2'd3, 1'b0);
        chk("rq mem_valid", mem_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rq mem_drop",  mem_valid, 0);
        chk("rq ready",     req_ready, 1);
        chk("rq mem_addr",  mem_addr, 0);
        chk("rq mem_mask",  mem_mask, 0);
        #2 rst_n = 1'b1;
        mem_ready = 1'b1;
        step();
        chk("rq no_rsp",    rsp_valid, 0);
        chk("rq idle_mem",  mem_valid, 0);

        // Reset while waiting for read data; a later rvalid must be ignored.
        issue(1'b0, 64'h8000_0038, 64'd0, 2'd3, 1'b0);
        step();
        chk("rw busy", req_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rw rsp_valid", rsp_valid, 0);
        chk("rw mem_valid", mem_valid, 0);
        chk("rw mem_addr",  mem_addr, 0);
        chk("rw mem_wen",   mem_wen, 0);
        chk("rw rsp_rdata", rsp_rdata, 0);
        chk("rw rsp_err",   rsp_err, 0);
        chk("rw ready",     req_ready, 1);
        #3 rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rw no_rsp", rsp_valid, 0);
            chk("rw ready_after", req_ready, 1);
            step();
        end

        do_load("ld_post", 64'h8000_0040, 2'd3, 1'b0, 64'hFEDC_BA98_7654_3210, 8'hFF, 64'hFEDC_BA98_7654_3210);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
